// File: rtl/lector_contadores.sv
// lector_contadores: requester side of the counter-read interface.
// Sweeps the four per-FIFO pop counters (idx 0..3) with a req/valid handshake,
// latches each returned value, flags responder timeouts and pulses done.
// Optional build macro: LECTOR_CONTADORES_SUM_EN adds a registered sum output.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start while the main FSM reports idle
// S_REQ  | req high for counter idx, waiting for valid or timeout
// S_GAP  | one req-low cycle between reads, advances idx
// S_DONE | one-cycle done pulse, then back to S_IDLE
module lector_contadores #(
  parameter int DATA_W  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              idle,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              req,
  output logic [1:0]        idx,
  output logic [DATA_W-1:0] count_0,
  output logic [DATA_W-1:0] count_1,
  output logic [DATA_W-1:0] count_2,
  output logic [DATA_W-1:0] count_3,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
`ifdef LECTOR_CONTADORES_SUM_EN
  ,
  output logic [DATA_W+1:0] sum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Down-counter is loaded with TIMEOUT-1 so that terminal count (0) with no
  // valid is reached on the TIMEOUT-th cycle of req.
  localparam logic [3:0] TMR_LOAD = 4'(TIMEOUT - 1);

  state_t     state;
  state_t     state_n;
  logic [3:0] tmr;
  logic [3:0] tmr_n;
  logic [1:0] idx_n;
  logic       capture;
  logic       tmo_set;
  logic       tmo_clr;

  // Next-state, next-index, timer and capture/flag strobes.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    tmr_n   = tmr;
    capture = 1'b0;
    tmo_set = 1'b0;
    tmo_clr = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && idle) begin
          state_n = S_REQ;
          idx_n   = 2'd0;
          tmr_n   = TMR_LOAD;
          tmo_clr = 1'b1;
        end
      end
      S_REQ: begin
        // Losing idle aborts the sweep, even over a simultaneous response.
        if (!idle) begin
          state_n = S_IDLE;
        end else if (valid) begin
          capture = 1'b1;
          state_n = S_GAP;
        end else if (tmr == 4'd0) begin
          state_n = S_DONE;
          tmo_set = 1'b1;
        end else begin
          tmr_n = tmr - 4'd1;
        end
      end
      S_GAP: begin
        if (!idle) begin
          state_n = S_IDLE;
        end else if (idx == 2'd3) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + 2'd1;
          tmr_n   = TMR_LOAD;
          state_n = S_REQ;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, timer and index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tmr   <= 4'd0;
      idx   <= 2'd0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      idx   <= idx_n;
    end
  end

  // Handshake and status outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      req  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      req  <= (state_n == S_REQ);
      busy <= (state_n == S_REQ) || (state_n == S_GAP);
      done <= (state_n == S_DONE);
    end
  end

  // Sticky timeout flag: cleared when a sweep is accepted, set on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (tmo_clr) begin
      timeout_err <= 1'b0;
    end else if (tmo_set) begin
      timeout_err <= 1'b1;
    end
  end

  // Holding registers: only written by a valid response while in S_REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_0 <= '0;
      count_1 <= '0;
      count_2 <= '0;
      count_3 <= '0;
    end else if (capture) begin
      case (idx)
        2'd0:    count_0 <= data;
        2'd1:    count_1 <= data;
        2'd2:    count_2 <= data;
        default: count_3 <= data;
      endcase
    end
  end

`ifdef LECTOR_CONTADORES_SUM_EN
  // Sum is taken on entry to S_DONE; no capture can happen on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if ((state_n == S_DONE) && (state != S_DONE)) begin
      sum <= {2'b00, count_0} + {2'b00, count_1} + {2'b00, count_2} + {2'b00, count_3};
    end
  end
`endif

endmodule

// File: tb/tb_lector_contadores.sv
// Bench for lector_contadores: directed sweeps plus randomized responder
// latency, data, timeouts and aborts, checked against a sweep-level model.
module tb_lector_contadores;
  localparam int DATA_W  = 6;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = 99;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              idle;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              req;
  logic [1:0]        idx;
  logic [DATA_W-1:0] count_0;
  logic [DATA_W-1:0] count_1;
  logic [DATA_W-1:0] count_2;
  logic [DATA_W-1:0] count_3;
  logic              busy;
  logic              done;
  logic              timeout_err;
`ifdef LECTOR_CONTADORES_SUM_EN
  logic [DATA_W+1:0] sum;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [DATA_W-1:0] m_cnt [4];
  logic              m_tmo;

  lector_contadores #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .idle(idle), .data(data), .valid(valid),
    .req(req), .idx(idx),
    .count_0(count_0), .count_1(count_1), .count_2(count_2), .count_3(count_3),
    .busy(busy), .done(done), .timeout_err(timeout_err)
`ifdef LECTOR_CONTADORES_SUM_EN
    , .sum(sum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] dut_cnt(input int i);
    case (i)
      0:       return count_0;
      1:       return count_1;
      2:       return count_2;
      default: return count_3;
    endcase
  endfunction

  task automatic check_counts(input string tag);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("%s_count_%0d", tag, i), 32'(dut_cnt(i)), 32'(m_cnt[i]));
  endtask

  // One sweep. w[i] = wait cycles before valid for index i (>= TIMEOUT means
  // never answer); abort_idx drops idle on the first req cycle of that index.
  task automatic sweep(input int w[4], input logic [DATA_W-1:0] d[4], input int abort_idx);
    logic [DATA_W-1:0] exp_cnt [4];
    int  exp_done, tmo_idx, n_started, exp_sum;
    bit  exp_abort, aborted, bad_order, prev_req, busy_at_done;
    int  abort_cyc, done_cyc, done_cnt, nreq, sum_at_done;
    int  req_cnt [4];

    // Model: each answered index costs (w+1) req cycles plus one gap cycle;
    // a timeout ends the sweep TIMEOUT cycles after that index's req rises.
    exp_cnt = m_cnt;
    exp_done = 1; tmo_idx = -1; n_started = 0; exp_abort = 0;
    for (int i = 0; i < 4; i++) begin
      n_started++;
      if (i == abort_idx) begin exp_abort = 1; break; end
      if (w[i] >= TIMEOUT) begin tmo_idx = i; exp_done += TIMEOUT; break; end
      exp_cnt[i] = d[i];
      exp_done += w[i] + 2;
    end
    exp_sum = 0;
    for (int i = 0; i < 4; i++) exp_sum += int'(exp_cnt[i]);

    aborted = 0; abort_cyc = 0; done_cyc = -1; done_cnt = 0; nreq = 0;
    bad_order = 0; prev_req = 0; busy_at_done = 1; sum_at_done = 0;
    for (int i = 0; i < 4; i++) req_cnt[i] = 0;

    @(negedge clk);
    start = 1'b1; idle = 1'b1; valid = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = 1'b0; valid = 1'b0; data = DATA_W'($urandom);
      if (cyc == 1) check_val("busy_on", 32'(busy), 1);
      if (aborted && cyc == abort_cyc + 1) begin
        check_val("abort_req", 32'(req), 0);
        check_val("abort_busy", 32'(busy), 0);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
`ifdef LECTOR_CONTADORES_SUM_EN
          sum_at_done = int'(sum);
`endif
        end
      end
      if (req && !prev_req) begin
        if (int'(idx) != nreq) bad_order = 1;
        nreq++;
      end
      prev_req = req;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (aborted && cyc >= abort_cyc + 5) break;
      if (req) begin
        req_cnt[idx]++;
        if (int'(idx) == abort_idx && !aborted) begin
          idle = 1'b0; aborted = 1; abort_cyc = cyc;
        end else if (req_cnt[idx] == w[idx] + 1) begin
          valid = 1'b1; data = d[idx];
        end
      end else if ($urandom_range(0, 3) == 0) begin
        valid = 1'b1; data = DATA_W'(33);
      end
    end
    idle = 1'b1; valid = 1'b0;

    check_val("aborted", 32'(aborted), 32'(exp_abort));
    check_val("idx_order", 32'(bad_order), 0);
    check_val("n_requests", 32'(nreq), 32'(n_started));
    if (exp_abort) begin
      check_val("abort_no_done", 32'(done_cnt), 0);
      m_tmo = 1'b0;
    end else begin
      check_val("done_cycle", 32'(done_cyc), 32'(exp_done));
      check_val("done_pulses", 32'(done_cnt), 1);
      check_val("busy_at_done", 32'(busy_at_done), 0);
      if (tmo_idx >= 0) check_val("req_high_timeout", 32'(req_cnt[tmo_idx]), TIMEOUT);
      m_tmo = (tmo_idx >= 0);
`ifdef LECTOR_CONTADORES_SUM_EN
      check_val("sum", 32'(sum_at_done), 32'(exp_sum));
`endif
    end
    m_cnt = exp_cnt;
    check_counts("sweep");
    check_val("timeout_err", 32'(timeout_err), 32'(m_tmo));
  endtask

  initial begin
    int w[4];
    logic [DATA_W-1:0] d[4];
    bit bad;

    rst = 1'b1; start = 1'b0; idle = 1'b1; valid = 1'b0; data = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    m_tmo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_val("rst_req", 32'(req), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_counts("rst");

    // Nominal sweep: valid one cycle after req.
    w = '{1, 1, 1, 1}; d = '{6'd5, 6'd12, 6'd0, 6'd63};
    sweep(w, d, -1);

    // Reset held two cycles in the middle of a sweep.
    @(negedge clk); start = 1'b1; idle = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); valid = 1'b1; data = DATA_W'(44);
    @(negedge clk); rst = 1'b1; valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    m_tmo = 1'b0;
    check_val("mid_rst_req", 32'(req), 0);
    check_val("mid_rst_idx", 32'(idx), 0);
    check_val("mid_rst_busy", 32'(busy), 0);
    check_val("mid_rst_done", 32'(done), 0);
    check_val("mid_rst_tmo", 32'(timeout_err), 0);
    check_counts("mid_rst");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_req", 32'(req), 0);

    // Zero-wait responder.
    w = '{0, 0, 0, 0}; d = '{6'd1, 6'd2, 6'd3, 6'd4};
    sweep(w, d, -1);

    // Responder silent for index 2.
    w = '{0, 2, NEVER, 0}; d = '{6'd20, 6'd21, 6'd22, 6'd23};
    sweep(w, d, -1);

    // idle drops during the request for index 1.
    w = '{1, 1, 1, 1}; d = '{6'd40, 6'd41, 6'd42, 6'd43};
    sweep(w, d, 1);

    // start while not idle is dropped; idle later rising starts nothing.
    bad = 0;
    @(negedge clk); start = 1'b1; idle = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (6) begin @(negedge clk); bad |= req | busy | done; end
    check_val("drop_start_idle0", 32'(bad), 0);
    bad = 0;
    idle = 1'b1;
    repeat (6) begin @(negedge clk); bad |= req | busy | done; end
    check_val("drop_start_idle1", 32'(bad), 0);
    check_counts("drop_start");

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) begin
        w[i] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
        d[i] = DATA_W'($urandom);
      end
      sweep(w, d, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
